// File: rtl/muldiv_unit.sv
// Multi-cycle MULTU/DIVU engine owning HI/LO; one iteration per cycle, done pulses once hi/lo are updated.
// stall_req holds the pipeline when a muldiv-class instruction arrives while the engine is busy or finishing.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;

  logic             is_md;
  logic             last_iter;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quot;

  assign is_md     = (alu_ctrl >= 4'd7) && (alu_ctrl <= 4'd10);
  assign last_iter = (count_q == CW'(WIDTH - 1));

  // Multiply: acc holds {partial product, consumed multiplier bits}; opa = multiplicand, opb = multiplier.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (opb_q[0] ? opa_q : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc upper half is the remainder; opa shifts the dividend out MSB first into the quotient.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opb_q) : div_shift[WIDTH-1:0];
  assign div_quot  = {opa_q[WIDTH-2:0], div_ge};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    unique case (state_q)
      IDLE: begin
        if (start && alu_ctrl == 4'd7) begin
          opa_d   = a;
          opb_d   = b;
          acc_d   = '0;
          count_d = '0;
          state_d = MUL;
        end else if (start && alu_ctrl == 4'd8) begin
          if (b != '0) begin
            opa_d   = a;
            opb_d   = b;
            acc_d   = '0;
            count_d = '0;
            state_d = DIV;
          end else begin
            hi_d    = a;
            lo_d    = {WIDTH{1'b1}};
            state_d = DONE;
          end
        end
      end
      MUL: begin
        acc_d   = mul_next;
        opb_d   = opb_q >> 1;
        count_d = count_q + 1'b1;
        if (last_iter) begin
          {hi_d, lo_d} = mul_next;
          state_d      = DONE;
        end
      end
      DIV: begin
        acc_d   = {div_rem, acc_q[WIDTH-1:0]};
        opa_d   = div_quot;
        count_d = count_q + 1'b1;
        if (last_iter) begin
          hi_d    = div_rem;
          lo_d    = div_quot;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
    end
  end

  assign busy      = (state_q == MUL) || (state_q == DIV);
  assign done      = (state_q == DONE);
  assign stall_req = (busy || done) && start && is_md;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign result    = (alu_ctrl == 4'd9)  ? hi_q :
                     (alu_ctrl == 4'd10) ? lo_q : '0;
endmodule

// File: tb/tb_muldiv_unit.sv
// Table-driven and randomized bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] a, b;
  logic         busy, done, stall_req;
  logic [W-1:0] hi, lo, result;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_ctrl(alu_ctrl), .a(a), .b(b),
    .busy(busy), .done(done), .stall_req(stall_req), .hi(hi), .lo(lo), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] exp_hilo;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    if (c == 4'd7)      p = 64'(x) * 64'(y);
    else if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
    else                p = {x % y, x / y};
    return p;
  endfunction

  // Issue one op for a single cycle, then wait (bounded) for done; lat counts negedges after accept.
  task automatic run_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic saw_busy);
    @(negedge clk);
    start = 1'b1; alu_ctrl = c; a = x; b = y;
    @(negedge clk);
    start = 1'b0; alu_ctrl = 4'd0;
    lat = 1;
    saw_busy = busy;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      saw_busy = saw_busy | busy;
    end
  endtask

  vec_t        vecs[$];
  int          lat;
  logic        sb;
  logic [63:0] exp;
  logic [31:0] rx, ry, old_lo;
  logic [3:0]  rc;

  initial begin
    rst = 1'b1; start = 1'b0; alu_ctrl = 4'd0; a = '0; b = '0;
    #12;
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33});
    vecs.push_back('{4'd8, 32'd100,       32'd7,         {32'd2, 32'd14},         33});
    vecs.push_back('{4'd8, 32'h1234,      32'd0,         {32'h1234, 32'hFFFF_FFFF}, 1});
    vecs.push_back('{4'd7, 32'd3,         32'd5,         {32'd0, 32'd15},         33});
    vecs.push_back('{4'd8, 32'hFFFF_FFFF, 32'd1,         {32'd0, 32'hFFFF_FFFF},  33});
    vecs.push_back('{4'd8, 32'd5,         32'd9,         {32'd5, 32'd0},          33});
    vecs.push_back('{4'd7, 32'h8000_0000, 32'd2,         {32'd1, 32'd0},          33});
    vecs.push_back('{4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'd0, 32'd1},          33});
    vecs.push_back('{4'd7, 32'd0,         32'hDEAD_BEEF, 64'd0,                   33});

    foreach (vecs[i]) begin
      run_op(vecs[i].c, vecs[i].x, vecs[i].y, lat, sb);
      check($sformatf("vec%0d_hilo", i), {hi, lo}, vecs[i].exp_hilo);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      if (vecs[i].exp_lat == 1) check($sformatf("vec%0d_busy_never", i), {63'd0, sb}, 64'd0);
      @(negedge clk);
      alu_ctrl = 4'd9;
      #1 check($sformatf("vec%0d_mfhi", i), {32'd0, result}, {32'd0, vecs[i].exp_hilo[63:32]});
      alu_ctrl = 4'd10;
      #1 check($sformatf("vec%0d_mflo", i), {32'd0, result}, {32'd0, vecs[i].exp_hilo[31:0]});
      alu_ctrl = 4'd2;
      #1 check($sformatf("vec%0d_result_other", i), {32'd0, result}, 64'd0);
      alu_ctrl = 4'd0;
    end

    // Stall while busy: MFLO sees old lo; non-muldiv codes do not stall; DONE still stalls.
    old_lo = lo;
    @(negedge clk);
    start = 1'b1; alu_ctrl = 4'd7; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0; alu_ctrl = 4'd0;
    repeat (9) @(negedge clk);
    start = 1'b1; alu_ctrl = 4'd2;
    #1 check("busy_add_no_stall", {63'd0, stall_req}, 64'd0);
    alu_ctrl = 4'd10;
    #1 check("busy_mflo_stall", {63'd0, stall_req}, 64'd1);
    check("busy_mflo_old_lo", {32'd0, result}, {32'd0, old_lo});
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("done_stall", {62'd0, done, stall_req}, 64'd3);
    start = 1'b0;
    check("stall_mul_lo", {32'd0, lo}, 64'd15);
    @(negedge clk);
    check("after_done_idle", {62'd0, busy, done}, 64'd0);

    // Asynchronous reset mid-divide.
    @(negedge clk);
    start = 1'b1; alu_ctrl = 4'd8; a = 32'hFFFF_0000; b = 32'd3;
    @(negedge clk);
    start = 1'b0; alu_ctrl = 4'd0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("arst_busy_done", {62'd0, busy, done}, 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(4'd7, 32'd6, 32'd7, lat, sb);
    check("post_rst_mul", {hi, lo}, 64'd42);

    // Non-muldiv start in IDLE changes nothing.
    @(negedge clk);
    start = 1'b1; alu_ctrl = 4'd2; a = 32'h55; b = 32'h66;
    #1 check("idle_add_no_stall", {63'd0, stall_req}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    check("idle_add_hilo", {hi, lo}, 64'd42);
    check("idle_add_busy", {62'd0, busy, done}, 64'd0);

    // Randomized ops against the arithmetic model.
    for (int k = 0; k < 24; k++) begin
      rc = ($urandom_range(0, 1) == 0) ? 4'd7 : 4'd8;
      rx = $urandom;
      case ($urandom_range(0, 3))
        0: ry = 32'd0;
        1: ry = 32'($urandom_range(1, 255));
        default: ry = $urandom;
      endcase
      exp = model(rc, rx, ry);
      run_op(rc, rx, ry, lat, sb);
      check($sformatf("rand%0d_op%0d_hilo", k, rc), {hi, lo}, exp);
      check($sformatf("rand%0d_latency", k), 64'(lat), (rc == 4'd8 && ry == 32'd0) ? 64'd1 : 64'd33);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
